// File: rtl/fpu_pkg.sv
// Shared FPU definitions: operand widths, sign-injection modes and the
// sign-injection helper used by every FSGNJ-family unit.
package fpu_pkg;

    localparam int FLEN_S = 32;
    localparam int FLEN_D = 64;

    typedef enum logic [1:0] {
        SGNJ      = 2'b00,
        SGNJN     = 2'b01,
        SGNJX     = 2'b10,
        SGNJ_PASS = 2'b11
    } sgnj_mode_t;

    // Operands narrower than FLEN_D are passed left-aligned, so the sign
    // always lives in bit FLEN_D-1 regardless of precision.
    function automatic logic [FLEN_D-1:0] sign_inject(
        input sgnj_mode_t        mode,
        input logic [FLEN_D-1:0] x1,
        input logic              x2sign,
        input logic              x1sign
    );
        logic sign;
        case (mode)
            SGNJ:    sign = x2sign;
            SGNJN:   sign = ~x2sign;
            SGNJX:   sign = x1sign ^ x2sign;
            default: sign = x1sign;
        endcase
        // Flip the sign bit in place only where it differs from x1.
        return x1 ^ {x1[FLEN_D-1] ^ sign, {(FLEN_D-1){1'b0}}};
    endfunction

endpackage

// File: rtl/pipe_stage.sv
// Single elastic register slice: loads when empty or when draining in the
// same cycle, so a chain of these collapses bubbles and keeps full rate.
module pipe_stage #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             up_valid,
    output logic             up_ready,
    input  logic [WIDTH-1:0] up_data,
    output logic             dn_valid,
    input  logic             dn_ready,
    output logic [WIDTH-1:0] dn_data
);

    logic             valid_q;
    logic [WIDTH-1:0] data_q;

    assign up_ready = ~valid_q | dn_ready;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples its upstream neighbour's pre-edge value.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_q <= 1'b0;
            // NOTE: data is reset too, so the output reads zero until the
            // first valid result rather than X.
            data_q  <= '0;
        end else begin
            if (flush) begin
                valid_q <= 1'b0;
            end else if (up_ready) begin
                valid_q <= up_valid;
            end
            if (up_valid && up_ready) begin
                data_q <= up_data;
            end
        end
    end

endmodule

// File: rtl/fsgnj_pipe.sv
// Pipelined FSGNJ/FSGNJN/FSGNJX unit with tag pass-through and an elastic
// valid/ready pipe of STAGES slices (0 = purely combinational).
module fsgnj_pipe
    import fpu_pkg::*;
#(
    parameter int FLEN   = 32,
    parameter int STAGES = 1,
    parameter int TAGW   = 5
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_mode,
    input  logic [FLEN-1:0] in_x1,
    input  logic [FLEN-1:0] in_x2,
    input  logic [TAGW-1:0] in_tag,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FLEN-1:0] out_y,
    output logic [TAGW-1:0] out_tag
);

    localparam int W     = FLEN + TAGW;
    localparam int ALIGN = FLEN_D - FLEN;

    logic [FLEN-1:0] y_calc;

    // The result is formed once at the input; stages only carry it.
    assign y_calc = FLEN'(sign_inject(sgnj_mode_t'(in_mode),
                                      FLEN_D'(in_x1) << ALIGN,
                                      in_x2[FLEN-1],
                                      in_x1[FLEN-1]) >> ALIGN);

    // Only the sign of x2 matters; flush is inert when STAGES is 0.
    logic unused_bits;
    assign unused_bits = ^{in_x2[FLEN-2:0], flush};

    logic [STAGES:0] vld;
    logic [STAGES:0] rdy;
    logic [W-1:0]    dat [STAGES+1];

    assign vld[0]         = in_valid;
    assign dat[0]         = {in_tag, y_calc};
    assign in_ready       = rdy[0];
    assign rdy[STAGES]    = out_ready;
    assign out_valid      = vld[STAGES];
    assign {out_tag, out_y} = dat[STAGES];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        pipe_stage #(
            .WIDTH(W)
        ) u_stage (
            .clk      (clk),
            .rstn     (rstn),
            .flush    (flush),
            .up_valid (vld[k]),
            .up_ready (rdy[k]),
            .up_data  (dat[k]),
            .dn_valid (vld[k+1]),
            .dn_ready (rdy[k+1]),
            .dn_data  (dat[k+1])
        );
    end

endmodule

// File: tb/tb_fsgnj_pipe.sv
// Self-checking bench for fsgnj_pipe across STAGES 0..3 and both precisions,
// with directed cases and randomized backpressure against a queue model.
module tb_fsgnj_pipe;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: magnitude from x1, sign chosen by mode from the two sign bits.
    function automatic logic [63:0] ref_sgnj(input int flen, input logic [1:0] mode,
                                             input logic [63:0] x1, input logic [63:0] x2);
        logic s1, s2, s;
        logic [63:0] r;
        s1 = x1[flen-1];
        s2 = x2[flen-1];
        case (mode)
            2'd0:    s = s2;
            2'd1:    s = !s2;
            2'd2:    s = s1 ^ s2;
            default: s = s1;
        endcase
        r = x1;
        r[flen-1] = s;
        return r;
    endfunction

    // a: FLEN=32 STAGES=1
    logic a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [1:0] a_in_mode; logic [31:0] a_in_x1, a_in_x2, a_out_y; logic [4:0] a_in_tag, a_out_tag;
    // b: FLEN=32 STAGES=3
    logic b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [1:0] b_in_mode; logic [31:0] b_in_x1, b_in_x2, b_out_y; logic [4:0] b_in_tag, b_out_tag;
    // c: FLEN=64 STAGES=2
    logic c_flush, c_in_valid, c_in_ready, c_out_valid, c_out_ready;
    logic [1:0] c_in_mode; logic [63:0] c_in_x1, c_in_x2, c_out_y; logic [4:0] c_in_tag, c_out_tag;
    // z: FLEN=32 STAGES=0
    logic z_flush, z_in_valid, z_in_ready, z_out_valid, z_out_ready;
    logic [1:0] z_in_mode; logic [31:0] z_in_x1, z_in_x2, z_out_y; logic [4:0] z_in_tag, z_out_tag;

    fsgnj_pipe #(.FLEN(32), .STAGES(1), .TAGW(5)) u_a (
        .clk(clk), .rstn(rstn), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_mode(a_in_mode), .in_x1(a_in_x1), .in_x2(a_in_x2), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_y(a_out_y), .out_tag(a_out_tag));

    fsgnj_pipe #(.FLEN(32), .STAGES(3), .TAGW(5)) u_b (
        .clk(clk), .rstn(rstn), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_mode(b_in_mode), .in_x1(b_in_x1), .in_x2(b_in_x2), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_y(b_out_y), .out_tag(b_out_tag));

    fsgnj_pipe #(.FLEN(64), .STAGES(2), .TAGW(5)) u_c (
        .clk(clk), .rstn(rstn), .flush(c_flush), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_mode(c_in_mode), .in_x1(c_in_x1), .in_x2(c_in_x2), .in_tag(c_in_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_y(c_out_y), .out_tag(c_out_tag));

    fsgnj_pipe #(.FLEN(32), .STAGES(0), .TAGW(5)) u_z (
        .clk(clk), .rstn(rstn), .flush(z_flush), .in_valid(z_in_valid), .in_ready(z_in_ready),
        .in_mode(z_in_mode), .in_x1(z_in_x1), .in_x2(z_in_x2), .in_tag(z_in_tag),
        .out_valid(z_out_valid), .out_ready(z_out_ready), .out_y(z_out_y), .out_tag(z_out_tag));

    task automatic op_a(input logic [1:0] m, input logic [31:0] x1, input logic [31:0] x2,
                        input logic [4:0] t, input logic [31:0] exp);
        a_in_valid = 1'b1; a_in_mode = m; a_in_x1 = x1; a_in_x2 = x2; a_in_tag = t;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check("a_valid", a_out_valid, 1'b1);
        check("a_y", a_out_y, exp);
        check("a_tag", a_out_tag, t);
        @(posedge clk); #1;
        check("a_drained", a_out_valid, 1'b0);
    endtask

    task automatic b_drive(input logic v, input logic [1:0] m, input logic [31:0] x1,
                           input logic [31:0] x2, input logic [4:0] t);
        b_in_valid = v; b_in_mode = m; b_in_x1 = x1; b_in_x2 = x2; b_in_tag = t;
    endtask

    typedef struct {
        logic [31:0] y;
        logic [4:0]  tag;
    } res_t;

    initial begin
        res_t        q[$];
        logic [31:0] sx1 [8];
        logic [31:0] sx2 [8];
        logic [31:0] sexp [8];
        int          idx, rcv, seen;
        logic        v, acc, emit;
        logic [1:0]  m;
        logic [31:0] x1, x2;
        logic [4:0]  t;

        {a_flush, a_in_valid, a_in_mode, a_in_x1, a_in_x2, a_in_tag} = '0;
        {b_flush, b_in_valid, b_in_mode, b_in_x1, b_in_x2, b_in_tag} = '0;
        {c_flush, c_in_valid, c_in_mode, c_in_x1, c_in_x2, c_in_tag} = '0;
        {z_flush, z_in_valid, z_in_mode, z_in_x1, z_in_x2, z_in_tag} = '0;
        a_out_ready = 1'b1; b_out_ready = 1'b1; c_out_ready = 1'b1; z_out_ready = 1'b1;

        #2;
        check("rst_a_valid", a_out_valid, 1'b0);
        check("rst_a_y", a_out_y, 32'h0);
        check("rst_a_tag", a_out_tag, 5'h0);
        check("rst_a_in_ready", a_in_ready, 1'b1);
        check("rst_b_in_ready", b_in_ready, 1'b1);
        check("rst_c_y", c_out_y, 64'h0);
        #10 rstn = 1'b1;
        @(posedge clk); #1;

        // STAGES=1 directed modes and special operands
        op_a(2'd0, 32'h3F800000, 32'hC0000000, 5'd1, 32'hBF800000);
        op_a(2'd1, 32'h3F800000, 32'hC0000000, 5'd2, 32'h3F800000);
        op_a(2'd2, 32'h3F800000, 32'hC0000000, 5'd3, 32'hBF800000);
        op_a(2'd3, 32'h3F800000, 32'hC0000000, 5'd4, 32'h3F800000);
        op_a(2'd0, 32'h7FC00001, 32'h80000000, 5'd5, 32'hFFC00001);
        op_a(2'd2, 32'h80000000, 32'h80000000, 5'd6, 32'h00000000);

        // Asynchronous reset between edges with a result in flight
        a_in_valid = 1'b1; a_in_mode = 2'd0; a_in_x1 = 32'h3F800000; a_in_x2 = 32'hC0000000; a_in_tag = 5'd7;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("arst_valid", a_out_valid, 1'b0);
        check("arst_y", a_out_y, 32'h0);
        check("arst_tag", a_out_tag, 5'h0);
        #3 rstn = 1'b1;
        @(posedge clk); #1;
        check("arst_no_stale", a_out_valid, 1'b0);
        op_a(2'd1, 32'h40490FDB, 32'h00000000, 5'd9, 32'hC0490FDB);

        // FLEN=64 STAGES=2 latency
        c_in_valid = 1'b1; c_in_mode = 2'd0; c_in_x1 = 64'h3FF0000000000000;
        c_in_x2 = 64'h8000000000000000; c_in_tag = 5'd11;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        check("c_lat1", c_out_valid, 1'b0);
        @(posedge clk); #1;
        check("c_valid", c_out_valid, 1'b1);
        check("c_y", c_out_y, 64'hBFF0000000000000);
        check("c_tag", c_out_tag, 5'd11);
        @(posedge clk); #1;
        check("c_drained", c_out_valid, 1'b0);

        // STAGES=0 is a combinational path
        z_in_valid = 1'b1; z_in_mode = 2'd1; z_in_x1 = 32'h40490FDB; z_in_x2 = 32'h0; z_in_tag = 5'd17;
        z_out_ready = 1'b0;
        #1;
        check("z_valid", z_out_valid, 1'b1);
        check("z_in_ready_lo", z_in_ready, 1'b0);
        check("z_y", z_out_y, 32'hC0490FDB);
        check("z_tag", z_out_tag, 5'd17);
        z_out_ready = 1'b1;
        #1;
        check("z_in_ready_hi", z_in_ready, 1'b1);
        z_in_valid = 1'b0;
        #1;
        check("z_idle", z_out_valid, 1'b0);
        @(posedge clk); #1;

        // STAGES=3: fill under stall, then release and stream out in order
        for (int i = 0; i < 8; i++) begin
            sx1[i]  = $urandom;
            sx2[i]  = $urandom;
            sexp[i] = 32'(ref_sgnj(32, 2'(i % 4), {32'h0, sx1[i]}, {32'h0, sx2[i]}));
        end
        b_out_ready = 1'b0;
        idx = 0;
        for (int cyc = 0; cyc < 8; cyc++) begin
            b_drive(idx < 8, 2'(idx % 4), sx1[idx % 8], sx2[idx % 8], 5'(idx));
            #1;
            acc = b_in_valid && b_in_ready;
            if (b_out_valid) begin
                check("stall_y", b_out_y, sexp[0]);
                check("stall_tag", b_out_tag, 5'd0);
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        check("stall_accepts", idx, 3);
        check("stall_in_ready", b_in_ready, 1'b0);
        check("stall_out_valid", b_out_valid, 1'b1);

        b_out_ready = 1'b1;
        rcv = 0;
        for (int cyc = 0; cyc < 30 && rcv < 8; cyc++) begin
            b_drive(idx < 8, 2'(idx % 4), sx1[idx % 8], sx2[idx % 8], 5'(idx));
            #1;
            acc = b_in_valid && b_in_ready;
            if (b_out_valid) begin
                check("flow_y", b_out_y, sexp[rcv]);
                check("flow_tag", b_out_tag, 5'(rcv));
                rcv++;
            end else if (rcv > 0) begin
                check("flow_gap", b_out_valid, 1'b1);
            end
            @(posedge clk); #1;
            if (acc) idx++;
        end
        b_drive(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
        check("flow_count", rcv, 8);

        // Flush with two ops in flight and a third offered alongside it
        b_out_ready = 1'b0;
        b_drive(1'b1, 2'd0, 32'h11111111, 32'h80000000, 5'd20);
        @(posedge clk); #1;
        b_drive(1'b1, 2'd1, 32'h22222222, 32'h80000000, 5'd21);
        @(posedge clk); #1;
        b_drive(1'b1, 2'd2, 32'h33333333, 32'h80000000, 5'd22);
        b_flush = 1'b1;
        @(posedge clk); #1;
        b_flush = 1'b0;
        b_drive(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
        check("flush_valid", b_out_valid, 1'b0);
        check("flush_in_ready", b_in_ready, 1'b1);
        b_out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            if (b_out_valid) seen++;
            @(posedge clk); #1;
        end
        check("flush_none_emitted", seen, 0);

        // Randomized traffic and backpressure against a FIFO model
        for (int cyc = 0; cyc < 3000; cyc++) begin
            v  = ($urandom_range(0, 9) < 7);
            m  = 2'($urandom_range(0, 3));
            x1 = $urandom;
            x2 = $urandom;
            t  = 5'($urandom_range(0, 31));
            b_drive(v, m, x1, x2, t);
            b_out_ready = ($urandom_range(0, 9) < 6);
            #1;
            check("rnd_in_ready", b_in_ready, !(q.size() >= 3 && !b_out_ready));
            emit = b_out_valid && b_out_ready;
            acc  = v && b_in_ready;
            if (emit) begin
                if (q.size() == 0) begin
                    check("rnd_spurious", 1'b1, 1'b0);
                end else begin
                    check("rnd_y", b_out_y, q[0].y);
                    check("rnd_tag", b_out_tag, q[0].tag);
                    void'(q.pop_front());
                end
            end
            if (acc) q.push_back('{y: 32'(ref_sgnj(32, m, {32'h0, x1}, {32'h0, x2})), tag: t});
            @(posedge clk); #1;
        end
        b_drive(1'b0, 2'd0, 32'h0, 32'h0, 5'd0);
        b_out_ready = 1'b1;
        for (int cyc = 0; cyc < 10; cyc++) begin
            #1;
            if (b_out_valid) begin
                if (q.size() == 0) begin
                    check("drain_spurious", 1'b1, 1'b0);
                end else begin
                    check("drain_y", b_out_y, q[0].y);
                    check("drain_tag", b_out_tag, q[0].tag);
                    void'(q.pop_front());
                end
            end
            @(posedge clk); #1;
        end
        check("rnd_no_loss", q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench did not complete");
    end

endmodule

// File: doc/fsgnj_pipe.md
Name: fsgnj_pipe

Overview:
- Parametrised, pipelined sign-injection unit for the FPU; successor to the single-mode combinational fsgnj_s.
- Implements FSGNJ, FSGNJN and FSGNJX on FLEN-bit operands; mode is selected per operation.
- Carries a destination tag through the pipe.
- Uses an elastic valid/ready pipeline of configurable depth, so it sits in the FPU issue/writeback path beside the other fixed-latency units.

Parameters:
- FLEN, 32, operand width; supported values 32 and 64; sign bit is FLEN-1.
- STAGES, 1, number of register stages, 0..3; 0 gives a combinational path.
- TAGW, 5, width of the pass-through tag (rd index).

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- flush  in  1  synchronous kill of all in-flight operations.
- in_valid  in  1  input operation valid.
- in_ready  out  1  unit can accept an input this cycle.
- in_mode  in  2  operation: 00 FSGNJ, 01 FSGNJN, 10 FSGNJX, 11 reserved (x1 passed unchanged).
- in_x1  in  FLEN  magnitude source.
- in_x2  in  FLEN  sign source; only bit FLEN-1 is used.
- in_tag  in  TAGW  tag, returned unchanged.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- out_y  out  FLEN  result.
- out_tag  out  TAGW  tag of the result.

Behaviour:
- Arithmetic:
  - out_y[FLEN-2:0] = x1[FLEN-2:0].
  - Sign is x2s for FSGNJ, ~x2s for FSGNJN, x1s^x2s for FSGNJX, x1s for mode 11.
  - Pure bit operation: NaN, Inf, zero and subnormal operands are neither canonicalised nor flagged; no exception outputs.
- The result is computed combinationally at the input and registered in stage 0; later stages only move data.
- Each stage k holds v[k], y[k] and tag[k].
- Stage advance:
  - Stage k loads from upstream when it is empty, or when it is being drained in the same cycle.
  - The last stage drains when out_valid && out_ready.
  - in_ready = ~v[0] | advance[0]; the ready chain is combinational back to the input.
- Transfer happens only on valid && ready at either boundary.
- Latency: exactly STAGES cycles from input transfer to out_valid when there is no stall.
- Throughput: one operation per cycle with out_ready held high.
- Stall:
  - out_valid=1 with out_ready=0 holds out_y and out_tag stable.
  - Upstream stages keep filling until full, then in_ready falls.
  - Capacity is STAGES entries.
- Ordering is strictly FIFO; no reordering and no bypass when STAGES>0.
- STAGES=0: out_valid=in_valid, in_ready=out_ready, out_y/out_tag are combinational; flush has no effect.
- flush: all v[k] go to 0 at the next edge.
  - An input presented in the same cycle as flush is discarded, even if in_ready=1.
  - in_ready is 1 in the cycle after a flush.
- Reset (rstn=0, asynchronous): all v[k]=0 and all data/tag registers=0, so out_valid=0, out_y=0, out_tag=0 and in_ready=1.
  - Reset mid-operation drops all in-flight results without emitting them.
  - Deassertion is synchronised outside the block.
- Inputs other than in_valid are ignored while in_valid=0.
- Data registers need not reload when v=0, but out_y must be 0 after reset until the first valid result.

Decomposition:
- Shared package fpu_pkg holds:
  - the sgnj_mode_t enum {SGNJ, SGNJN, SGNJX, SGNJ_PASS};
  - FLEN_S=32 and FLEN_D=64;
  - a sign_inject function (mode, x1, x2sign, x1sign) -> FLEN-bit result, reused by fsgnj_s and future units.
- One sub-module is natural: pipe_stage, a single elastic register slice (valid/ready, WIDTH parameter).
  - fsgnj_pipe instantiates STAGES copies of it in a generate loop.

Test Plan:
- STAGES=1, FLEN=32: x1=0x3F800000, x2=0xC0000000, mode 00 -> after 1 cycle out_y=0xBF800000; mode 01 -> 0x3F800000; mode 10 -> 0xBF800000.
- Special operands: x1=0x7FC00001 (NaN), x2=0x80000000, mode 00 -> out_y=0xFFC00001, payload untouched. x1=0x80000000, x2=0x80000000, mode 10 -> out_y=0x00000000.
- STAGES=3:
  - Stream 8 ops with tags 0..7 and out_ready=0 -> in_ready falls after exactly 3 accepts, and out_y/out_tag stay stable.
  - Release out_ready -> 8 results emerge in tag order with no gap once flowing.
- FLEN=64, STAGES=2: x1=0x3FF0000000000000, x2=0x8000000000000000, mode 00 -> out_y=0xBFF0000000000000 after 2 cycles.
- flush with 2 ops in flight plus an input offered in the same cycle -> out_valid=0 next cycle, none of the 3 ops ever appears, in_ready=1.
- Assert rstn=0 mid-stream between clock edges -> out_valid=0 and out_y=0 immediately.
  - After release, a new op with tag 9 produces one result with tag 9 and nothing stale.
- Random: 1M ops with random valid/ready backpressure versus a scoreboard model -> zero mismatches, no loss, no duplication.
